// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the multiply/divide unit state type.
package riscv_pkg;

    localparam logic [6:0] OP_REG        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. One shared 2*XLEN shift
// register serves both shift-add multiplication and restoring division;
// signs are stripped on entry and re-applied on the final step.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  operand1,
    input  logic [XLEN-1:0]  operand2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t     state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   mag2_reg;
    logic [2:0]        f3_reg;
    logic              neg_res_reg;
    logic              neg_rem_reg;
    logic [XLEN-1:0]   result_reg;
    logic [TAG_W-1:0]  out_tag_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    // Input decode: which operands are signed, their magnitudes, special cases
    logic            is_div, s1_signed, s2_signed, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_result;

    // Operand sign handling and division special-case detection
    always_comb begin
        is_div    = funct3[2];
        s1_signed = is_div ? !funct3[0] : (funct3 != F3_MULHU);
        s2_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                    (funct3 == F3_DIV) || (funct3 == F3_REM);
        neg1      = s1_signed && operand1[XLEN-1];
        neg2      = s2_signed && operand2[XLEN-1];
        // The most negative value negates to itself, which is its correct
        // unsigned magnitude.
        mag1      = neg1 ? -operand1 : operand1;
        mag2      = neg2 ? -operand2 : operand2;
        div_zero  = is_div && (operand2 == '0);
        div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (operand2 == '1);
        special   = div_zero || div_ovf;
        if (funct3[1])
            special_result = div_zero ? operand1 : '0;
        else
            special_result = div_zero ? '1 : operand1;
    end

    // One iteration step plus sign correction and result selection
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_result;

    // Shift-add / restoring-divide step on the shared accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                   (acc_reg[0] ? {1'b0, mag2_reg} : '0);
        mul_next = {mul_sum, acc_reg[XLEN-1:1]};

        rem_sh   = acc_reg[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, mag2_reg};
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};

        acc_next = f3_reg[2] ? div_next : mul_next;

        prod = neg_res_reg ? -acc_next : acc_next;
        quo  = neg_res_reg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = neg_rem_reg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

        case (f3_reg)
            F3_MUL:                  final_result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                final_result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:         final_result = quo;
            default:                 final_result = rem;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mag2_reg      <= '0;
            f3_reg        <= '0;
            neg_res_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            result_reg    <= '0;
            out_tag_reg   <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        f3_reg      <= funct3;
                        out_tag_reg <= in_tag;
                        neg_res_reg <= neg1 ^ neg2;
                        neg_rem_reg <= neg1;
                        mag2_reg    <= mag2;
                        busy_reg    <= 1'b1;
                        if (special) begin
                            result_reg    <= special_result;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            acc_reg   <= {{XLEN{1'b0}}, mag1};
                            cnt_reg   <= CNT_W'(XLEN);
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        result_reg    <= final_result;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign out_tag   = out_tag_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN = 32 with hand-computed results.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  operand1;
    logic [XLEN-1:0]  operand2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .operand1  (operand1),
        .operand2  (operand2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Present one op at posedge+1; returns just after the accepting edge
    task automatic start_op(input string name, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        funct3   = f3;
        operand1 = a;
        operand2 = b;
        in_tag   = tag;
        in_valid = 1'b1;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges counted from the accepting edge (inclusive) until out_valid
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp,
                         input int exp_lat);
        int lat;
        start_op(name, f3, a, b, tag);
        wait_valid(lat);
        check({name, " result"}, 64'(result), 64'(exp));
        check({name, " tag"}, 64'(out_tag), 64'(tag));
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        $display("op %s a=%08h b=%08h tag=%0d -> result=%08h tag=%0d lat=%0d",
                 name, a, b, tag, result, out_tag, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
        check({name, " out_valid cleared"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        funct3    = '0;
        operand1  = '0;
        operand2  = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Multiplies
        do_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
        do_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33);
        do_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33);
        do_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33);

        // Normal divides
        do_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
        do_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        do_op("DIVU",   3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       33);
        do_op("REMU",   3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        33);

        // Special cases
        do_op("DIV0",   3'b100, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
        do_op("REMU0",  3'b111, 32'd5,        32'd0,        5'd12, 32'd5,        1);
        do_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
        do_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1);

        // Backpressure: hold DONE for 5 cycles
        start_op("BP", 3'b000, 32'd6, 32'd9, 5'd17);
        check("BP busy in CALC", 64'(busy), 64'd1);
        wait_valid(lat);
        check("BP latency", 64'(lat), 64'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("BP hold result", 64'(result), 64'd54);
            check("BP hold tag", 64'(out_tag), 64'd17);
            check("BP hold out_valid", 64'(out_valid), 64'd1);
            check("BP hold in_ready", 64'(in_ready), 64'd0);
        end
        $display("op BP held 5 cycles result=%08h tag=%0d", result, out_tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("BP in_ready after release", 64'(in_ready), 64'd1);
        do_op("B2B", 3'b101, 32'd1000, 32'd10, 5'd18, 32'd100, 33);

        // Flush with in_valid in IDLE: not accepted
        flush    = 1'b1;
        funct3   = 3'b000;
        operand1 = 32'd1;
        operand2 = 32'd1;
        in_tag   = 5'd19;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+valid not accepted busy", 64'(busy), 64'd0);
        $display("op FLUSH_IDLE busy=%0d", busy);

        // Flush 10 cycles into CALC
        start_op("FL", 3'b000, 32'd3, 32'd3, 5'd20);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("FL in_ready", 64'(in_ready), 64'd1);
        check("FL busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("FL out_valid never", 64'(seen), 64'd0);
        $display("op FLUSH_CALC out_valid cycles=%0d", seen);

        // Reset mid-CALC
        start_op("RS", 3'b011, 32'd5, 32'd5, 5'd21);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("RS in_ready during reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("RS in_ready after reset", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("RS out_valid never", 64'(seen), 64'd0);
        $display("op RESET_CALC out_valid cycles=%0d", seen);

        // Recovery
        do_op("MULHU2", 3'b011, 32'h12345678, 32'h00000100, 5'd22, 32'h00000012, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
